// File: rtl/seg_scan.sv
// Eight-digit time-multiplexed scanner for a common-anode seven-segment display.
// Frames are double-buffered and swapped only at the start of a scan frame.
module seg_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] digits,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp,
  output logic [7:0]  an,
  output logic [3:0]  nibble,
  output logic        dp_n,
  output logic        frame_start,
  output logic        dbg_state
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYC);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  // r_cnt/r_idx hold the phase and slot that the next edge will display.
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  state_t        r_state;
  state_t        w_state_next;

  logic [31:0] r_pend_digits, r_act_digits;
  logic [7:0]  r_pend_en, r_act_en;
  logic [7:0]  r_pend_dp, r_act_dp;

  logic [31:0] w_pend_digits, w_act_digits;
  logic [7:0]  w_pend_en, w_act_en;
  logic [7:0]  w_pend_dp, w_act_dp;
  logic        w_boundary;

  logic [7:0]  w_an_next;
  logic [3:0]  w_nib_next;
  logic        w_dpn_next;

  assign w_boundary = (r_idx == 3'd0) && (r_cnt == '0);

  // A load on the boundary edge bypasses straight into the active buffer.
  assign w_pend_digits = load ? digits   : r_pend_digits;
  assign w_pend_en     = load ? digit_en : r_pend_en;
  assign w_pend_dp     = load ? dp       : r_pend_dp;

  assign w_act_digits = w_boundary ? w_pend_digits : r_act_digits;
  assign w_act_en     = w_boundary ? w_pend_en     : r_act_en;
  assign w_act_dp     = w_boundary ? w_pend_dp     : r_act_dp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_digits <= 32'd0;
      r_pend_en     <= 8'd0;
      r_pend_dp     <= 8'd0;
      r_act_digits  <= 32'd0;
      r_act_en      <= 8'd0;
      r_act_dp      <= 8'd0;
    end else begin
      r_pend_digits <= w_pend_digits;
      r_pend_en     <= w_pend_en;
      r_pend_dp     <= w_pend_dp;
      r_act_digits  <= w_act_digits;
      r_act_en      <= w_act_en;
      r_act_dp      <= w_act_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_BLANK;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = ST_ON;
    if (r_cnt < BLANK_C) w_state_next = ST_BLANK;
  end

  always_comb begin
    w_an_next  = 8'hFF;
    w_dpn_next = 1'b1;
    w_nib_next = w_act_digits[{r_idx, 2'b00} +: 4];
    if (w_state_next == ST_ON) begin
      w_an_next[r_idx] = ~w_act_en[r_idx];
      w_dpn_next       = ~(w_act_dp[r_idx] & w_act_en[r_idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an          <= 8'hFF;
      nibble      <= 4'd0;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= w_an_next;
      nibble      <= w_nib_next;
      dp_n        <= w_dpn_next;
      frame_start <= w_boundary;
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV=4, BLANK_CYC=1.
// Edge k counts rising edges since the last reset release (first edge is k=1).
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] digits;
  logic [7:0]  digit_en;
  logic [7:0]  dp;
  logic [7:0]  an;
  logic [3:0]  nibble;
  logic        dp_n;
  logic        frame_start;
  logic        dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  seg_scan #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk(clk), .rst(rst), .load(load), .digits(digits), .digit_en(digit_en),
    .dp(dp), .an(an), .nibble(nibble), .dp_n(dp_n), .frame_start(frame_start),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load = 1'b0;
    digits = '0;
    digit_en = '0;
    dp = '0;
    tick();
    tick();
    rst = 1'b0;
    k = 0;
  endtask

  // Load a frame on edge 1, which is a frame boundary, so it is committed at once.
  task automatic reset_and_load(input logic [31:0] d, input logic [7:0] en, input logic [7:0] p);
    do_reset();
    load = 1'b1;
    digits = d;
    digit_en = en;
    dp = p;
    tick();
    load = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (k < n) tick();
  endtask

  function automatic logic [7:0] exp_an(input int kk, input logic [7:0] en);
    int s, p;
    logic [7:0] a;
    s = ((kk - 1) / 4) % 8;
    p = (kk - 1) % 4;
    a = 8'hFF;
    if (p != 0 && en[s]) a[s] = 1'b0;
    return a;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    load = 1'b0;
    digits = 32'hFFFF_FFFF;
    digit_en = 8'hFF;
    dp = 8'hFF;
    repeat (3) tick();
    vectors++;
    if (an !== 8'hFF || nibble !== 4'h0 || dp_n !== 1'b1 || frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: an=%h nibble=%h dp_n=%b fs=%b, want an=ff nibble=0 dp_n=1 fs=0",
               an, nibble, dp_n, frame_start);
    end
    rst = 1'b0;
    digits = '0;
    digit_en = '0;
    dp = '0;
    k = 0;
    // No load yet: buffers hold zeros, so every digit is disabled.
    for (int i = 1; i <= 33; i++) begin
      tick();
      vectors++;
      if (an !== 8'hFF || nibble !== 4'h0 || dp_n !== 1'b1 ||
          frame_start !== (k == 1 || k == 33)) begin
        miscompares++;
        $display("FAIL reset_idle k=%0d: an=%h nibble=%h dp_n=%b fs=%b", k, an, nibble, dp_n, frame_start);
      end
    end
  endtask

  task automatic test_scan();
    reset_and_load(32'h0, 8'hFF, 8'h00);
    for (int i = 1; i <= 65; i++) begin
      if (i > 1) tick();
      vectors++;
      if (an !== exp_an(k, 8'hFF) || nibble !== 4'h0 || dp_n !== 1'b1) begin
        miscompares++;
        $display("FAIL scan k=%0d: an=%h nibble=%h dp_n=%b, want an=%h nibble=0 dp_n=1",
                 k, an, nibble, dp_n, exp_an(k, 8'hFF));
      end
      vectors++;
      if (frame_start !== (k == 1 || k == 33 || k == 65)) begin
        miscompares++;
        $display("FAIL scan_fs k=%0d: frame_start=%b", k, frame_start);
      end
      vectors++;
      if (dbg_state !== ((k - 1) % 4 != 0)) begin
        miscompares++;
        $display("FAIL scan_state k=%0d: state=%b", k, dbg_state);
      end
    end
  endtask

  task automatic test_load_commit();
    reset_and_load(32'h0, 8'hFF, 8'h00);
    run_to(9);
    load = 1'b1;
    digits = 32'h8765_4321;
    digit_en = 8'hFF;
    dp = 8'h01;
    tick();
    load = 1'b0;
    digits = '0;
    dp = '0;
    while (k < 32) begin
      tick();
      vectors++;
      if (an !== exp_an(k, 8'hFF) || nibble !== 4'h0 || dp_n !== 1'b1) begin
        miscompares++;
        $display("FAIL load_hold k=%0d: an=%h nibble=%h dp_n=%b, want old frame", k, an, nibble, dp_n);
      end
    end
    tick();
    vectors++;
    if (frame_start !== 1'b1 || an !== 8'hFF) begin
      miscompares++;
      $display("FAIL load_boundary k=33: fs=%b an=%h, want fs=1 an=ff", frame_start, an);
    end
    while (k < 40) begin
      tick();
      if (k >= 34 && k <= 36) begin
        vectors++;
        if (an !== 8'hFE || nibble !== 4'h1 || dp_n !== 1'b0) begin
          miscompares++;
          $display("FAIL load_slot0 k=%0d: an=%h nibble=%h dp_n=%b, want fe 1 0", k, an, nibble, dp_n);
        end
      end
      if (k >= 38) begin
        vectors++;
        if (an !== 8'hFD || nibble !== 4'h2 || dp_n !== 1'b1) begin
          miscompares++;
          $display("FAIL load_slot1 k=%0d: an=%h nibble=%h dp_n=%b, want fd 2 1", k, an, nibble, dp_n);
        end
      end
    end
  endtask

  task automatic test_disabled();
    reset_and_load(32'hFFFF_FFFF, 8'b1010_0101, 8'h00);
    for (int i = 1; i <= 33; i++) begin
      if (i > 1) tick();
      vectors++;
      if (an !== exp_an(k, 8'b1010_0101) || nibble !== 4'hF || dp_n !== 1'b1 ||
          frame_start !== (k == 1 || k == 33)) begin
        miscompares++;
        $display("FAIL disabled k=%0d: an=%h nibble=%h dp_n=%b fs=%b, want an=%h nibble=f",
                 k, an, nibble, dp_n, frame_start, exp_an(k, 8'b1010_0101));
      end
    end
  endtask

  task automatic test_back_to_back();
    reset_and_load(32'h0, 8'hFF, 8'h00);
    run_to(19);
    load = 1'b1;
    digits = 32'h1111_1111;
    tick();
    load = 1'b0;
    run_to(24);
    load = 1'b1;
    digits = 32'h2222_2222;
    tick();
    load = 1'b0;
    digits = '0;
    while (k < 64) begin
      tick();
      if (k >= 34) begin
        vectors++;
        if (nibble !== 4'h2 || an !== exp_an(k, 8'hFF)) begin
          miscompares++;
          $display("FAIL last_wins k=%0d: nibble=%h an=%h, want nibble=2 an=%h", k, nibble, an, exp_an(k, 8'hFF));
        end
      end
    end
  endtask

  task automatic test_boundary_bypass();
    reset_and_load(32'h0, 8'hFF, 8'h00);
    run_to(32);
    vectors++;
    if (an !== 8'h7F || nibble !== 4'h0) begin
      miscompares++;
      $display("FAIL bypass_pre k=32: an=%h nibble=%h, want 7f 0", an, nibble);
    end
    load = 1'b1;
    digits = 32'hAAAA_AAAA;
    tick();
    load = 1'b0;
    digits = '0;
    vectors++;
    if (frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_fs k=33: frame_start=%b, want 1", frame_start);
    end
    while (k < 36) begin
      tick();
      vectors++;
      if (an !== 8'hFE || nibble !== 4'hA) begin
        miscompares++;
        $display("FAIL bypass k=%0d: an=%h nibble=%h, want fe a", k, an, nibble);
      end
    end
  endtask

  task automatic test_mid_reset();
    reset_and_load(32'h8765_4321, 8'hFF, 8'hFF);
    run_to(47);
    vectors++;
    if (an !== 8'hF7 || nibble !== 4'h4 || dp_n !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset k=47: an=%h nibble=%h dp_n=%b, want f7 4 0", an, nibble, dp_n);
    end
    // Leave a pending frame behind that reset must discard.
    load = 1'b1;
    digits = 32'h9999_9999;
    tick();
    load = 1'b0;
    run_to(49);
    rst = 1'b1;
    tick();
    vectors++;
    if (an !== 8'hFF || nibble !== 4'h0 || dp_n !== 1'b1 || frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: an=%h nibble=%h dp_n=%b fs=%b, want ff 0 1 0", an, nibble, dp_n, frame_start);
    end
    rst = 1'b0;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      vectors++;
      if (an !== 8'hFF || nibble !== 4'h0 || dp_n !== 1'b1 || frame_start !== (k == 1)) begin
        miscompares++;
        $display("FAIL post_reset k=%0d: an=%h nibble=%h dp_n=%b fs=%b", k, an, nibble, dp_n, frame_start);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    digits = '0;
    digit_en = '0;
    dp = '0;
    test_reset();
    test_scan();
    test_load_commit();
    test_disabled();
    test_back_to_back();
    test_boundary_bypass();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
